// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets and colour-bar table shared by the sync generator.
package vga_pkg;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
    v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23
  };

  typedef enum logic [2:0] {
    BAR_WHITE   = 3'd0,
    BAR_YELLOW  = 3'd1,
    BAR_CYAN    = 3'd2,
    BAR_GREEN   = 3'd3,
    BAR_MAGENTA = 3'd4,
    BAR_RED     = 3'd5,
    BAR_BLUE    = 3'd6,
    BAR_BLACK   = 3'd7
  } bar_e;

  // Returns {r, g, b}, one bit per channel; the caller replicates to full width.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      BAR_WHITE:   c = 3'b111;
      BAR_YELLOW:  c = 3'b110;
      BAR_CYAN:    c = 3'b011;
      BAR_GREEN:   c = 3'b010;
      BAR_MAGENTA: c = 3'b101;
      BAR_RED:     c = 3'b100;
      BAR_BLUE:    c = 3'b001;
      default:     c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay.sv
// rtl/vga_delay.sv - N-stage shift register with async reset to zero; N=0 is a wire.
module vga_delay #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (N == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_sr
      logic [W-1:0] sr [N];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA counters, pixel requests, latency-aligned sync and blanked RGB output.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int RGB_WIDTH = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIX_LAT   = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 test_mode,
  input  logic [RGB_WIDTH-1:0]                                 pix_r,
  input  logic [RGB_WIDTH-1:0]                                 pix_g,
  input  logic [RGB_WIDTH-1:0]                                 pix_b,
  output logic                                                 pix_req,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         pix_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         pix_y,
  output logic                                                 frame_start,
  output logic                                                 hsync,
  output logic                                                 vsync,
  output logic [RGB_WIDTH-1:0]                                 r,
  output logic [RGB_WIDTH-1:0]                                 g,
  output logic [RGB_WIDTH-1:0]                                 b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SEG     = H_ACTIVE / 8;
  localparam int SW      = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int DW      = 6;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(SEG - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic [SW-1:0] seg_cnt;
  logic [2:0]    bar_idx;
  logic [DW-1:0] dly_in;
  logic [DW-1:0] dly_out;
  logic          act_d;
  logic          hs_d;
  logic          vs_d;
  logic [2:0]    bar_d;
  logic [2:0]    bar_c;
  logic          mode_q;
  logic          mode_sel;

  assign h_wrap = (h == H_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign active      = (h < H_ACT) && (v < V_ACT);
  assign hs_raw      = (h >= HS_FIRST) && (h <= HS_LAST);
  assign vs_raw      = (v >= VS_FIRST) && (v <= VS_LAST);
  assign pix_req     = active;
  assign frame_start = (h == '0) && (v == '0);
  assign pix_x       = h;
  assign pix_y       = v;

  // Bar index tracks the current column; cleared on the way into h=0 so it is 0 there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_cnt <= '0;
      bar_idx <= '0;
    end else if (h_wrap) begin
      seg_cnt <= '0;
      bar_idx <= '0;
    end else if (h < H_ACT) begin
      if (seg_cnt == SEG_LAST) begin
        seg_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        seg_cnt <= seg_cnt + 1'b1;
      end
    end
  end

  assign dly_in = {active, hs_raw, vs_raw, bar_idx};

  vga_delay #(
    .W(DW),
    .N(PIX_LAT)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .din (dly_in),
    .dout(dly_out)
  );

  assign {act_d, hs_d, vs_d, bar_d} = dly_out;
  assign bar_c = bar_rgb(bar_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (frame_start) begin
      mode_q <= test_mode;
    end
  end

  // With zero latency pixel (0,0) is emitted in the frame_start cycle itself.
  assign mode_sel = frame_start ? test_mode : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else begin
      hsync <= hs_d ? HS_POL : ~HS_POL;
      vsync <= vs_d ? VS_POL : ~VS_POL;
      if (!act_d) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else if (mode_sel) begin
        r <= {RGB_WIDTH{bar_c[2]}};
        g <= {RGB_WIDTH{bar_c[1]}};
        b <= {RGB_WIDTH{bar_c[0]}};
      end else begin
        r <= pix_r;
        g <= pix_g;
        b <= pix_b;
      end
    end
  end

endmodule
